// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for a 5-stage CPU.
// 32 lines of 256 bits with per-line valid/dirty/tag; one line transfer per memory request.
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_req_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int TAG_W = 22;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t               state_r;
  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [LINE_W-1:0]    data_r [NUM_LINES];

  logic [4:0]        idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [2:0]        word_s;
  logic [7:0]        bit_off_s;
  logic [LINE_W-1:0] line_s;
  logic              active_s;
  logic              hit_s;
  logic              wr_hit_s;
  logic              fill_s;
  logic              unused_s;

  assign idx_s     = p1_addr_i[9:5];
  assign tag_s     = p1_addr_i[31:10];
  assign word_s    = p1_addr_i[4:2];
  assign bit_off_s = {word_s, 5'b00000};
  assign line_s    = data_r[idx_s];
  assign unused_s  = ^p1_addr_i[1:0];

  // Request decode, hit detection and the two array-write enables
  always_comb begin
    active_s = p1_req_i & (p1_MemRead_i | p1_MemWrite_i);
    hit_s    = valid_r[idx_s] & (tag_r[idx_s] == tag_s);
    wr_hit_s = (state_r == IDLE) & active_s & p1_MemWrite_i & hit_s;
    fill_s   = (state_r == ALLOCATE) & mem_ack_i;
  end

  // Load data is the addressed word of the indexed line, valid in the hit cycle
  always_comb begin
    p1_data_o = 32'd0;
    p1_data_o = line_s[bit_off_s +: 32];
  end

  // Stall is combinational in IDLE so a hit costs nothing; any transfer state stalls
  always_comb begin
    p1_stall_o = 1'b1;
    if (state_r == IDLE) begin
      p1_stall_o = active_s & ~hit_s;
    end else begin
      p1_stall_o = 1'b1;
    end
  end

  // Controller FSM with registered memory-side outputs and valid/dirty bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      valid_r      <= '0;
      dirty_r      <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= 32'd0;
      mem_data_o   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (active_s && !hit_s) begin
            mem_enable_o <= 1'b1;
            if (dirty_r[idx_s]) begin
              state_r     <= WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_r[idx_s], idx_s, 5'b00000};
              mem_data_o  <= line_s;
            end else begin
              state_r     <= ALLOCATE;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {p1_addr_i[31:5], 5'b00000};
            end
          end else if (wr_hit_s) begin
            dirty_r[idx_s] <= 1'b1;
          end
        end
        WRITEBACK: begin
          // Enable stays high across the switch to the fetch: no gap between transfers
          if (mem_ack_i) begin
            state_r     <= ALLOCATE;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {p1_addr_i[31:5], 5'b00000};
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state_r        <= FILL;
            mem_enable_o   <= 1'b0;
            valid_r[idx_s] <= 1'b1;
            dirty_r[idx_s] <= 1'b0;
          end
        end
        FILL: begin
          state_r <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid gates every use of them
  always_ff @(posedge clk_i) begin
    if (!rst_i && fill_s) begin
      data_r[idx_s] <= mem_data_i;
      tag_r[idx_s]  <= tag_s;
    end else if (!rst_i && wr_hit_s) begin
      data_r[idx_s][bit_off_s +: 32] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a latency-programmable line memory model.
module tb_dcache_ctrl;

  logic         clk;
  logic         rst;
  logic         p1_req, p1_rd, p1_wr;
  logic [31:0]  p1_addr, p1_wdata;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  logic         model_ack, man_ack;
  logic [255:0] model_data, man_data;
  int           mem_lat;
  int           cnt;
  int           wb_count, fetch_count;
  logic [31:0]  wb_addr, fetch_addr;
  logic [255:0] wb_data;
  time          wb_t, fetch_t;

  int total, bad;
  int stalls;
  logic [31:0] rdata;

  assign mem_ack_i  = model_ack | man_ack;
  assign mem_data_i = man_ack ? man_data : model_data;

  dcache_ctrl #(.NUM_LINES(32), .LINE_W(256)) dut (
    .clk_i(clk), .rst_i(rst),
    .p1_req_i(p1_req), .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
    .p1_addr_i(p1_addr), .p1_data_i(p1_wdata), .p1_data_o(p1_data_o),
    .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word w of the line at address a is {a[15:0], 8'hA0+w, 8'h5C}
  function automatic logic [255:0] line_for(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {a[15:0], 8'hA0 + 8'(w), 8'h5C};
    return l;
  endfunction

  // Memory: acks in the mem_lat-th consecutive cycle of mem_enable_o and logs the transfer
  always @(negedge clk) begin
    if (mem_enable_o) begin
      cnt = cnt + 1;
      if (cnt >= mem_lat) begin
        model_ack  = 1'b1;
        model_data = line_for(mem_addr_o);
        if (mem_write_o) begin
          wb_count = wb_count + 1; wb_addr = mem_addr_o; wb_data = mem_data_o; wb_t = $time;
        end else begin
          fetch_count = fetch_count + 1; fetch_addr = mem_addr_o; fetch_t = $time;
        end
        cnt = 0;
      end else begin
        model_ack = 1'b0;
      end
    end else begin
      cnt = 0;
      model_ack = 1'b0;
    end
  end

  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] d, output int st, output logic [31:0] q);
    @(negedge clk);
    p1_req = 1'b1; p1_addr = a; p1_rd = rd; p1_wr = wr; p1_wdata = d;
    #1;
    st = 0;
    while (p1_stall_o && st < 200) begin
      st++;
      @(negedge clk); #1;
    end
    q = p1_data_o;
    @(negedge clk);
    p1_req = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL reset_mem_enable got=%b want=0", mem_enable_o); end
    total++; if (mem_write_o !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b want=0", mem_write_o); end
    total++; if (p1_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", p1_stall_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_cold_read;
    access(32'h0000_0404, 1'b1, 1'b0, 32'd0, stalls, rdata);
    total++; if (stalls != 12) begin bad++; $display("FAIL cold_stalls got=%0d want=12", stalls); end
    total++; if (fetch_count != 1) begin bad++; $display("FAIL cold_fetch_count got=%0d want=1", fetch_count); end
    total++; if (fetch_addr !== 32'h0000_0400) begin bad++; $display("FAIL cold_fetch_addr got=%h want=00000400", fetch_addr); end
    total++; if (rdata !== 32'h0400_A15C) begin bad++; $display("FAIL cold_data got=%h want=0400a15c", rdata); end
  endtask

  task automatic test_write_hit;
    access(32'h0000_0404, 1'b0, 1'b1, 32'hDEAD_BEEF, stalls, rdata);
    total++; if (stalls != 0) begin bad++; $display("FAIL wh_write_stalls got=%0d want=0", stalls); end
    access(32'h0000_0404, 1'b1, 1'b0, 32'd0, stalls, rdata);
    total++; if (stalls != 0) begin bad++; $display("FAIL wh_read_stalls got=%0d want=0", stalls); end
    total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wh_data got=%h want=deadbeef", rdata); end
  endtask

  task automatic test_dirty_evict;
    access(32'h0000_0804, 1'b1, 1'b0, 32'd0, stalls, rdata);
    total++; if (stalls != 22) begin bad++; $display("FAIL ev_stalls got=%0d want=22", stalls); end
    total++; if (wb_count != 1) begin bad++; $display("FAIL ev_wb_count got=%0d want=1", wb_count); end
    total++; if (wb_addr !== 32'h0000_0400) begin bad++; $display("FAIL ev_wb_addr got=%h want=00000400", wb_addr); end
    total++; if (wb_data[63:32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ev_wb_word1 got=%h want=deadbeef", wb_data[63:32]); end
    total++; if (wb_data[31:0] !== 32'h0400_A05C) begin bad++; $display("FAIL ev_wb_word0 got=%h want=0400a05c", wb_data[31:0]); end
    total++; if (fetch_addr !== 32'h0000_0800) begin bad++; $display("FAIL ev_fetch_addr got=%h want=00000800", fetch_addr); end
    total++; if (!(wb_t < fetch_t)) begin bad++; $display("FAIL ev_order wb_t=%0t fetch_t=%0t want wb first", wb_t, fetch_t); end
    total++; if (rdata !== 32'h0800_A15C) begin bad++; $display("FAIL ev_data got=%h want=0800a15c", rdata); end
  endtask

  task automatic test_read_write_both;
    access(32'h0000_0010, 1'b1, 1'b1, 32'h1234_5678, stalls, rdata);
    total++; if (stalls != 12) begin bad++; $display("FAIL rw_stalls got=%0d want=12", stalls); end
    total++; if (fetch_addr !== 32'h0000_0000) begin bad++; $display("FAIL rw_fetch_addr got=%h want=00000000", fetch_addr); end
    total++; if (wb_count != 1) begin bad++; $display("FAIL rw_wb_count got=%0d want=1", wb_count); end
    access(32'h0000_0010, 1'b1, 1'b0, 32'd0, stalls, rdata);
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL rw_data got=%h want=12345678", rdata); end
  endtask

  task automatic test_back_to_back;
    access(32'h0000_0014, 1'b1, 1'b0, 32'd0, stalls, rdata);
    total++; if (stalls != 0) begin bad++; $display("FAIL b2b_stalls got=%0d want=0", stalls); end
    total++; if (rdata !== 32'h0000_A55C) begin bad++; $display("FAIL b2b_data got=%h want=0000a55c", rdata); end
    access(32'h0000_001C, 1'b1, 1'b0, 32'd0, stalls, rdata);
    total++; if (rdata !== 32'h0000_A75C) begin bad++; $display("FAIL b2b_word7 got=%h want=0000a75c", rdata); end
  endtask

  task automatic test_reset_in_allocate;
    mem_lat = 50;
    @(negedge clk);
    p1_req = 1'b1; p1_addr = 32'h0000_0040; p1_rd = 1'b1; p1_wr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) begin bad++; $display("FAIL ra_in_alloc en=%b wr=%b want en=1 wr=0", mem_enable_o, mem_write_o); end
    #2;
    rst = 1'b1; p1_req = 1'b0; p1_rd = 1'b0;
    #1;
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL ra_abort_enable got=%b want=0", mem_enable_o); end
    total++; if (p1_stall_o !== 1'b0) begin bad++; $display("FAIL ra_abort_stall got=%b want=0", p1_stall_o); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); man_data = '1; man_ack = 1'b1;
    @(negedge clk); man_ack = 1'b0;
    #1;
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL ra_late_ack_enable got=%b want=0", mem_enable_o); end
    mem_lat = 10;
    access(32'h0000_0040, 1'b1, 1'b0, 32'd0, stalls, rdata);
    total++; if (stalls != 12) begin bad++; $display("FAIL ra_remiss_stalls got=%0d want=12", stalls); end
    total++; if (rdata !== 32'h0040_A05C) begin bad++; $display("FAIL ra_remiss_data got=%h want=0040a05c", rdata); end
  endtask

  task automatic test_spurious_ack;
    int fc;
    fc = fetch_count;
    @(negedge clk); man_data = '1; man_ack = 1'b1;
    @(negedge clk); man_ack = 1'b0;
    #1;
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL sp_enable got=%b want=0", mem_enable_o); end
    access(32'h0000_0044, 1'b1, 1'b0, 32'd0, stalls, rdata);
    total++; if (stalls != 0) begin bad++; $display("FAIL sp_stalls got=%0d want=0", stalls); end
    total++; if (rdata !== 32'h0040_A15C) begin bad++; $display("FAIL sp_data got=%h want=0040a15c", rdata); end
    total++; if (fetch_count != fc) begin bad++; $display("FAIL sp_fetch_count got=%0d want=%0d", fetch_count, fc); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    p1_req = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;
    man_ack = 1'b0; man_data = '0; model_ack = 1'b0; model_data = '0;
    mem_lat = 10; cnt = 0; wb_count = 0; fetch_count = 0;
    wb_addr = 32'd0; fetch_addr = 32'd0; wb_data = '0; wb_t = 0; fetch_t = 0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_evict();
    test_read_write_both();
    test_back_to_back();
    test_reset_in_allocate();
    test_spurious_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
